ssd1289_bus_writer: RTL

Consumes the 17-bit {RS, DATA} word stream produced by the LCD initialisation and pixel logic, and drives the SSD1289 8080-style parallel write bus (RS, WR, RD, DB[15:0]). The block has an internal FIFO, so producers can emit one word per clock in a burst, for example a 40-word init sequence back-to-back. A timing FSM serialises the words onto the bus with programmable setup, WR-low and WR-high durations. It sits between the init/pixel sources and the LCD pins; chip-select stays with the init block.

---
 rtl/ssd1289_bus_writer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ssd1289_bus_writer.sv
// SSD1289 8080-style write-bus driver. Queues {RS, DB} words in a FIFO and
// serialises them onto RS/WR/DB with programmable setup, WR-low and WR-high
// phases. WR is idle high, and DB/RS hold the last word between transfers.
module ssd1289_bus_writer #(
  parameter int FIFO_DEPTH  = 64,
  parameter int SETUP_CYC   = 1,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [16:0] app_din,
  input  logic        app_din_valid,
  output logic        app_din_ready,
  output logic        bus_RS,
  output logic        bus_WR,
  output logic        bus_RD,
  output logic [15:0] bus_DB,
  output logic        busy,
  output logic        fifo_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 8;

  typedef enum logic [1:0] {IDLE, SETUP, WR_LOW, WR_HIGH} state_t;

  logic [16:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;

  state_t        r_state;
  logic [CW-1:0] r_cyc;
  logic          r_rs, r_wr;
  logic [15:0]   r_db;

  logic          w_full, w_empty, w_push, w_pop, w_hi_last;
  logic [16:0]   w_head;

  assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_push    = app_din_valid && !w_full;
  assign w_hi_last = (r_state == WR_HIGH) && (r_cyc == CW'(WR_HIGH_CYC - 1));
  // The FSM takes the head either from IDLE or on the last WR-high clock,
  // so back-to-back words chain without an IDLE bubble.
  assign w_pop     = !w_empty && ((r_state == IDLE) || w_hi_last);
  assign w_head    = r_mem[r_rp];

  assign app_din_ready = !w_full;
  assign busy          = (r_state != IDLE) || !w_empty;
  assign fifo_overflow = r_ovf;
  assign bus_RS        = r_rs;
  assign bus_WR        = r_wr;
  assign bus_DB        = r_db;
  assign bus_RD        = 1'b1;

  // FIFO storage; contents need no reset, validity is tracked by r_cnt.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wp] <= app_din;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (app_din_valid && w_full) r_ovf <= 1'b1;
    end
  end

  // Bus timing FSM with registered RS/WR/DB; the cycle counter restarts on every state change.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_rs    <= 1'b1;
      r_wr    <= 1'b1;
      r_db    <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          r_wr <= 1'b1;
          if (w_pop) begin
            r_rs    <= w_head[16];
            r_db    <= w_head[15:0];
            r_state <= SETUP;
            r_cyc   <= '0;
          end
        end
        SETUP: begin
          if (r_cyc == CW'(SETUP_CYC - 1)) begin
            r_wr    <= 1'b0;
            r_state <= WR_LOW;
            r_cyc   <= '0;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        WR_LOW: begin
          if (r_cyc == CW'(WR_LOW_CYC - 1)) begin
            r_wr    <= 1'b1;
            r_state <= WR_HIGH;
            r_cyc   <= '0;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        WR_HIGH: begin
          if (w_hi_last) begin
            r_cyc <= '0;
            if (w_pop) begin
              r_rs    <= w_head[16];
              r_db    <= w_head[15:0];
              r_state <= SETUP;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cyc   <= '0;
          r_wr    <= 1'b1;
        end
      endcase
    end
  end

endmodule
